scurve_sweep_ctrl: RTL and testbench

Sequencer for the S-curve threshold scan. It steps the DAC threshold code from a start value to an end value and requests a slow-control reload at each step. At each step it runs the single-channel S-curve measurement on one channel or on all CHN_NUM channels in turn. Before each channel's counter data it writes a header word into the data FIFO path. It sits between the USB command decoder and the single-channel S-curve block.

---
 rtl/scurve_sweep_ctrl.sv | 168 ++++++++++++++++
 tb/tb_scurve_sweep_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scurve_sweep_ctrl.sv
// S-curve threshold sweep sequencer: steps the DAC threshold, requests a slow-control
// reload per step, and runs the single-channel test on one or all channels with a header per channel.
module scurve_sweep_ctrl #(
    parameter int          CHN_NUM       = 64,
    parameter logic [15:0] SETTLE_CYCLES = 16'd1000
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        Sweep_Start,
    input  logic        Sweep_Abort,
    input  logic        Single_Chn_Mode,
    input  logic [5:0]  Single_Chn_Sel,
    input  logic [9:0]  DAC_Start,
    input  logic [9:0]  DAC_End,
    input  logic [9:0]  DAC_Step,
    input  logic        Config_Done,
    input  logic        One_Channel_Done,
    output logic [9:0]  DAC_Code,
    output logic        Config_Load,
    output logic [5:0]  Chn_Sel,
    output logic        Chn_Test_Start,
    output logic [15:0] Header_Data,
    output logic        Header_wr_en,
    output logic        Sweep_Busy,
    output logic        Sweep_Done
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD_CFG = 4'd1,
        WAIT_CFG = 4'd2,
        SETTLE   = 4'd3,
        HEADER   = 4'd4,
        CHN_RUN  = 4'd5,
        CHN_NEXT = 4'd6,
        DAC_NEXT = 4'd7,
        DONE     = 4'd8
    } state_t;

    localparam logic [5:0]  LAST_CHN    = 6'(CHN_NUM - 1);
    localparam logic [15:0] SETTLE_LAST = SETTLE_CYCLES - 16'd1;

    state_t      state_r;
    logic [15:0] settle_cnt_r;
    logic        single_r;
    logic [5:0]  chn_start_r;
    logic [9:0]  dac_end_r;
    logic [9:0]  dac_step_r;
    logic [10:0] dac_next_s;

    // 11-bit sum so a step past code 1023 is seen as beyond the end, never as a wrap
    assign dac_next_s  = {1'b0, DAC_Code} + {1'b0, dac_step_r};
    assign Header_Data = {DAC_Code, Chn_Sel};

    // Sweep state machine; every output is registered and set on entry to the state that owns it
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            settle_cnt_r   <= 16'd0;
            single_r       <= 1'b0;
            chn_start_r    <= 6'd0;
            dac_end_r      <= 10'd0;
            dac_step_r     <= 10'd0;
            DAC_Code       <= 10'd0;
            Chn_Sel        <= 6'd0;
            Config_Load    <= 1'b0;
            Chn_Test_Start <= 1'b0;
            Header_wr_en   <= 1'b0;
            Sweep_Busy     <= 1'b0;
            Sweep_Done     <= 1'b0;
        end else begin
            Config_Load  <= 1'b0;
            Header_wr_en <= 1'b0;
            Sweep_Done   <= 1'b0;
            if ((state_r != IDLE) && Sweep_Abort) begin
                state_r        <= IDLE;
                Chn_Test_Start <= 1'b0;
                Sweep_Busy     <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (Sweep_Start) begin
                            single_r    <= Single_Chn_Mode;
                            chn_start_r <= Single_Chn_Mode ? Single_Chn_Sel : 6'd0;
                            Chn_Sel     <= Single_Chn_Mode ? Single_Chn_Sel : 6'd0;
                            dac_end_r   <= DAC_End;
                            dac_step_r  <= DAC_Step;
                            DAC_Code    <= DAC_Start;
                            Sweep_Busy  <= 1'b1;
                            if (DAC_Start > DAC_End) begin
                                state_r    <= DONE;
                                Sweep_Done <= 1'b1;
                            end else begin
                                state_r     <= LOAD_CFG;
                                Config_Load <= 1'b1;
                            end
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    LOAD_CFG: begin
                        state_r <= WAIT_CFG;
                    end
                    WAIT_CFG: begin
                        if (Config_Done) begin
                            settle_cnt_r <= 16'd0;
                            state_r      <= SETTLE;
                        end else begin
                            state_r <= WAIT_CFG;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt_r >= SETTLE_LAST) begin
                            settle_cnt_r <= 16'd0;
                            state_r      <= HEADER;
                            Header_wr_en <= 1'b1;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + 16'd1;
                        end
                    end
                    HEADER: begin
                        state_r        <= CHN_RUN;
                        Chn_Test_Start <= 1'b1;
                    end
                    CHN_RUN: begin
                        // Drop the start level with the done so the channel block idles cleanly
                        if (One_Channel_Done) begin
                            Chn_Test_Start <= 1'b0;
                            state_r        <= CHN_NEXT;
                        end else begin
                            state_r <= CHN_RUN;
                        end
                    end
                    CHN_NEXT: begin
                        if (single_r || (Chn_Sel == LAST_CHN)) begin
                            state_r <= DAC_NEXT;
                        end else begin
                            Chn_Sel      <= Chn_Sel + 6'd1;
                            state_r      <= HEADER;
                            Header_wr_en <= 1'b1;
                        end
                    end
                    DAC_NEXT: begin
                        if ((dac_step_r == 10'd0) || (dac_next_s > {1'b0, dac_end_r})) begin
                            state_r    <= DONE;
                            Sweep_Done <= 1'b1;
                        end else begin
                            DAC_Code    <= dac_next_s[9:0];
                            Chn_Sel     <= chn_start_r;
                            state_r     <= LOAD_CFG;
                            Config_Load <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_r    <= IDLE;
                        Sweep_Busy <= 1'b0;
                    end
                    default: begin
                        state_r        <= IDLE;
                        Chn_Test_Start <= 1'b0;
                        Sweep_Busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scurve_sweep_ctrl.sv
// Scoreboard bench for scurve_sweep_ctrl: expected DAC reloads, headers and done pulses are
// queued by the stimulus thread and consumed by a negedge monitor.
module tb_scurve_sweep_ctrl;

    localparam int          CHN    = 4;
    localparam logic [15:0] SETTLE = 16'd5;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Sweep_Start = 1'b0;
    logic        Sweep_Abort = 1'b0;
    logic        Single_Chn_Mode = 1'b0;
    logic [5:0]  Single_Chn_Sel = 6'd0;
    logic [9:0]  DAC_Start = 10'd0;
    logic [9:0]  DAC_End = 10'd0;
    logic [9:0]  DAC_Step = 10'd0;
    logic        Config_Done;
    logic        One_Channel_Done;
    logic [9:0]  DAC_Code;
    logic        Config_Load;
    logic [5:0]  Chn_Sel;
    logic        Chn_Test_Start;
    logic [15:0] Header_Data;
    logic        Header_wr_en;
    logic        Sweep_Busy;
    logic        Sweep_Done;

    logic cfg_done_m = 1'b0;
    logic cfg_done_spur = 1'b0;
    logic ocd_m = 1'b0;
    assign Config_Done      = cfg_done_m | cfg_done_spur;
    assign One_Channel_Done = ocd_m;

    scurve_sweep_ctrl #(.CHN_NUM(CHN), .SETTLE_CYCLES(SETTLE)) dut (
        .Clk(Clk), .reset_n(reset_n), .Sweep_Start(Sweep_Start), .Sweep_Abort(Sweep_Abort),
        .Single_Chn_Mode(Single_Chn_Mode), .Single_Chn_Sel(Single_Chn_Sel),
        .DAC_Start(DAC_Start), .DAC_End(DAC_End), .DAC_Step(DAC_Step),
        .Config_Done(Config_Done), .One_Channel_Done(One_Channel_Done),
        .DAC_Code(DAC_Code), .Config_Load(Config_Load), .Chn_Sel(Chn_Sel),
        .Chn_Test_Start(Chn_Test_Start), .Header_Data(Header_Data), .Header_wr_en(Header_wr_en),
        .Sweep_Busy(Sweep_Busy), .Sweep_Done(Sweep_Done)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_hdr_q[$];
    logic [9:0]  exp_dac_q[$];
    int          exp_done_n = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got event with value 0x%0h, expected no event", name, act);
    endtask

    task automatic push_hdr(input logic [9:0] dac, input logic [5:0] chn);
        exp_hdr_q.push_back({dac, chn});
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_hdr_left"},  32'(exp_hdr_q.size()), 32'd0);
        chk({tag, "_load_left"}, 32'(exp_dac_q.size()), 32'd0);
        chk({tag, "_done_left"}, 32'(exp_done_n),       32'd0);
    endtask

    task automatic start_sweep(input logic single, input logic [5:0] sel,
                               input logic [9:0] s, input logic [9:0] e, input logic [9:0] st);
        @(negedge Clk);
        Single_Chn_Mode = single;
        Single_Chn_Sel  = sel;
        DAC_Start       = s;
        DAC_End         = e;
        DAC_Step        = st;
        Sweep_Start     = 1'b1;
        @(negedge Clk);
        Sweep_Start     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (Sweep_Busy && (n < budget)) begin
            @(negedge Clk);
            n++;
        end
        chk(name, 32'(Sweep_Busy), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every reload, header and done strobe
    initial begin
        logic prev_hdr;
        logic prev_cts;
        prev_hdr = 1'b0;
        prev_cts = 1'b0;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (Header_wr_en) begin
                    if (exp_hdr_q.size() == 0) unexpected("hdr_unexpected", 32'(Header_Data));
                    else chk("hdr_data", 32'(Header_Data), 32'(exp_hdr_q.pop_front()));
                    chk("hdr_cts_overlap", 32'(Chn_Test_Start), 32'd0);
                end
                if (Config_Load) begin
                    if (exp_dac_q.size() == 0) unexpected("load_unexpected", 32'(DAC_Code));
                    else chk("load_dac", 32'(DAC_Code), 32'(exp_dac_q.pop_front()));
                end
                if (Sweep_Done) begin
                    if (exp_done_n == 0) unexpected("done_unexpected", 32'(DAC_Code));
                    else exp_done_n--;
                end
                if (Chn_Test_Start && !prev_cts) chk("hdr_before_start", 32'(prev_hdr), 32'd1);
            end
            prev_hdr = Header_wr_en;
            prev_cts = Chn_Test_Start;
        end
    end

    // Slow-control model: Config_Done three cycles after each reload request
    initial begin
        int dly;
        dly = 0;
        forever begin
            @(negedge Clk);
            cfg_done_m = 1'b0;
            if (!reset_n) dly = 0;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) cfg_done_m = 1'b1;
            end else if (Config_Load) dly = 3;
        end
    end

    // Single-channel model: done pulse 20 cycles after the start level rises
    initial begin
        int   dly;
        bit   pend;
        logic prev;
        dly = 0;
        pend = 1'b0;
        prev = 1'b0;
        forever begin
            @(negedge Clk);
            ocd_m = 1'b0;
            if (pend) begin
                chk("cts_low_after_done", 32'(Chn_Test_Start), 32'd0);
                pend = 1'b0;
            end
            if (!reset_n) dly = 0;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    ocd_m = 1'b1;
                    pend  = 1'b1;
                end
            end else if (Chn_Test_Start && !prev) dly = 20;
            prev = Chn_Test_Start;
        end
    end

    initial begin
        bit found;
        #12;
        chk("rst_busy_done", {30'd0, Sweep_Busy, Sweep_Done}, 32'd0);
        chk("rst_code_sel",  {16'd0, DAC_Code, Chn_Sel}, 32'd0);
        chk("rst_strobes",   {29'd0, Config_Load, Header_wr_en, Chn_Test_Start}, 32'd0);
        @(negedge Clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Single channel 5, codes 100/105/110
        exp_dac_q.push_back(10'd100); exp_dac_q.push_back(10'd105); exp_dac_q.push_back(10'd110);
        exp_hdr_q.push_back(16'h1905); exp_hdr_q.push_back(16'h1A45); exp_hdr_q.push_back(16'h1B85);
        exp_done_n = 1;
        start_sweep(1'b1, 6'd5, 10'd100, 10'd110, 10'd5);
        chk("t1_busy_after_start", 32'(Sweep_Busy), 32'd1);
        wait_idle("t1_finish", 2000);
        chk_drained("t1");

        // Full scan of CHN channels at a single code
        exp_dac_q.push_back(10'd200);
        for (int c = 0; c < CHN; c++) push_hdr(10'd200, 6'(c));
        exp_done_n = 1;
        start_sweep(1'b0, 6'd9, 10'd200, 10'd200, 10'd1);
        wait_idle("t2_finish", 2000);
        chk_drained("t2");

        // Start above end: immediate done
        exp_done_n = 1;
        start_sweep(1'b1, 6'd0, 10'd300, 10'd200, 10'd1);
        chk("t3_done_latency", 32'(Sweep_Done), 32'd1);
        wait_idle("t3_finish", 20);
        chk_drained("t3");

        // Zero step: one point only
        exp_dac_q.push_back(10'd50);
        exp_hdr_q.push_back(16'h0C87);
        exp_done_n = 1;
        start_sweep(1'b1, 6'd7, 10'd50, 10'd60, 10'd0);
        wait_idle("t3b_finish", 2000);
        chk_drained("t3b");

        // Step past code 1023 must not wrap
        exp_dac_q.push_back(10'd1020);
        exp_hdr_q.push_back(16'hFF00);
        exp_done_n = 1;
        start_sweep(1'b1, 6'd0, 10'd1020, 10'd1023, 10'd8);
        wait_idle("t4_finish", 2000);
        chk_drained("t4");

        // Abort during channel 2, then restart from DAC_Start
        exp_dac_q.push_back(10'd10);
        for (int c = 0; c < 3; c++) push_hdr(10'd10, 6'(c));
        start_sweep(1'b0, 6'd0, 10'd10, 10'd20, 10'd10);
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(negedge Clk);
            #1;
            if (Chn_Test_Start && (Chn_Sel == 6'd2)) found = 1'b1;
        end
        chk("t5_reached_chn2", 32'(found), 32'd1);
        Sweep_Abort = 1'b1;
        @(negedge Clk);
        Sweep_Abort = 1'b0;
        chk("t5_abort_busy", 32'(Sweep_Busy), 32'd0);
        chk("t5_abort_cts",  32'(Chn_Test_Start), 32'd0);
        repeat (30) @(negedge Clk);
        chk_drained("t5_abort");
        exp_dac_q.push_back(10'd10);
        for (int c = 0; c < CHN; c++) push_hdr(10'd10, 6'(c));
        exp_dac_q.push_back(10'd20);
        for (int c = 0; c < CHN; c++) push_hdr(10'd20, 6'(c));
        exp_done_n = 1;
        start_sweep(1'b0, 6'd0, 10'd10, 10'd20, 10'd10);
        wait_idle("t5_restart_finish", 4000);
        chk_drained("t5_restart");
        chk("t5_code_held", 32'(DAC_Code), 32'd20);
        chk("t5_sel_held",  32'(Chn_Sel), 32'd3);

        // Asynchronous reset inside SETTLE, then a stray Config_Done
        exp_dac_q.push_back(10'd500);
        start_sweep(1'b1, 6'd3, 10'd500, 10'd600, 10'd50);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge Clk);
            #1;
            if (Config_Done) found = 1'b1;
        end
        chk("t6_cfg_done_seen", 32'(found), 32'd1);
        @(negedge Clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy_done", {30'd0, Sweep_Busy, Sweep_Done}, 32'd0);
        chk("t6_rst_code_sel",  {16'd0, DAC_Code, Chn_Sel}, 32'd0);
        chk("t6_rst_hdr",       32'(Header_Data), 32'd0);
        chk("t6_rst_strobes",   {29'd0, Config_Load, Header_wr_en, Chn_Test_Start}, 32'd0);
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);
        cfg_done_spur = 1'b1;
        @(negedge Clk);
        cfg_done_spur = 1'b0;
        repeat (SETTLE + 16'd10) @(negedge Clk);
        chk("t6_stays_idle", 32'(Sweep_Busy), 32'd0);
        chk_drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
